uart_receiver: RTL and testbench

Serial receive path for the board UART: recovers 8N1 frames from the asynchronous `Rx` pin and presents each byte to the fabric with a level-held `ready` flag. It is the receive-side counterpart to the existing UART transmit path and runs in the same 50 MHz domain. It contains its own 16x-oversampling tick generator, input synchronizer, framing check and overrun detection.

---
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling, two-flop input synchronizer,
// framing check and overrun detection, with a level-held ready flag.
module uart_receiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       Rx,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       Rx_busy
);

    localparam int               CNT_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVS_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    state_t           state_q, state_d;
    logic [3:0]       samp_q, samp_d;
    logic [2:0]       bitpos_q, bitpos_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_done;
    logic             frame_bad;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_MAX) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == CNT_MAX);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            samp_q   <= 4'd0;
            bitpos_q <= 3'd0;
            shreg_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            samp_q   <= samp_d;
            bitpos_q <= bitpos_d;
            shreg_q  <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bitpos_d  = bitpos_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        samp_d  = 4'd0;
                        state_d = START;
                    end
                end
                START: begin
                    if (samp_q == 4'd7) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            samp_d   = 4'd0;
                            bitpos_d = 3'd0;
                            state_d  = DATA;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                DATA: begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        // Line is LSB-first; shifting in at the MSB lands bit 0 at shreg[0].
                        shreg_d  = {rx_s, shreg_q[7:1]};
                        bitpos_d = bitpos_q + 3'd1;
                        if (bitpos_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        byte_done = rx_s;
                        frame_bad = ~rx_s;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A byte completing in the same cycle as an acknowledge wins: ready stays set.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= 8'h00;
            ready       <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            if (byte_done) begin
                data_out <= shreg_q;
                ready    <= 1'b1;
                overrun  <= ready_clr ? 1'b0 : (overrun | ready);
            end else if (ready_clr) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign Rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random bytes,
// checked against a frame-level model of ready/data_out/overrun.
module tb_uart_receiver;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int OVS      = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = OVS * 16;
    localparam int LAT_MIN  = 152 * OVS + 2 + 1;
    localparam int LAT_MAX  = 152 * OVS + OVS + 1 + 1;

    logic       clk_50m;
    logic       rst_n;
    logic       Rx;
    logic       ready_clr;
    logic [7:0] data_out;
    logic       ready;
    logic       framing_err;
    logic       overrun;
    logic       Rx_busy;

    int total;
    int bad;
    int cyc;
    int busy_cycles;
    int fe_cycles;
    int fe_pulses;
    int ready_rise_cyc;
    logic ready_prev;
    logic fe_prev;

    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_overrun;

    uart_receiver dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .Rx         (Rx),
        .ready_clr  (ready_clr),
        .data_out   (data_out),
        .ready      (ready),
        .framing_err(framing_err),
        .overrun    (overrun),
        .Rx_busy    (Rx_busy)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // Clock edges since reset release; the oversample phase follows from this.
    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk_50m) begin
        if (Rx_busy) busy_cycles <= busy_cycles + 1;
        if (framing_err) fe_cycles <= fe_cycles + 1;
        if (framing_err && !fe_prev) fe_pulses <= fe_pulses + 1;
        if (ready && !ready_prev) ready_rise_cyc <= cyc;
        fe_prev    <= framing_err;
        ready_prev <= ready;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        Rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            waitClocks(BIT_CLKS);
        end
        Rx = stop_bit;
        waitClocks(BIT_CLKS);
        Rx = 1'b1;
    endtask

    task automatic modelGoodFrame(input logic [7:0] b);
        exp_overrun = exp_overrun | exp_ready;
        exp_ready   = 1'b1;
        exp_data    = b;
    endtask

    task automatic pulseClear();
        @(negedge clk_50m);
        ready_clr = 1'b1;
        @(negedge clk_50m);
        ready_clr = 1'b0;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    task automatic checkModel(input string pfx);
        checkOutput({pfx, ".data_out"}, {24'd0, data_out}, {24'd0, exp_data});
        checkOutput({pfx, ".ready"}, {31'd0, ready}, {31'd0, exp_ready});
        checkOutput({pfx, ".overrun"}, {31'd0, overrun}, {31'd0, exp_overrun});
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, ".data_out"}, {24'd0, data_out}, 32'h0);
        checkOutput({pfx, ".ready"}, {31'd0, ready}, 32'h0);
        checkOutput({pfx, ".framing_err"}, {31'd0, framing_err}, 32'h0);
        checkOutput({pfx, ".overrun"}, {31'd0, overrun}, 32'h0);
        checkOutput({pfx, ".Rx_busy"}, {31'd0, Rx_busy}, 32'h0);
    endtask

    initial begin
        int p;
        int k;
        int kc;
        int guard;
        int b0;
        int fc0;
        int fp0;
        logic [7:0] rb;
        logic       do_clr;

        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        Rx          = 1'b1;
        ready_clr   = 1'b0;
        exp_data    = 8'h00;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;

        waitClocks(4);
        checkResetValues("reset");
        rst_n = 1'b1;
        waitClocks(10);

        // Single byte with start-to-ready latency
        p = cyc;
        applyStimulus(8'h55, 1'b1);
        modelGoodFrame(8'h55);
        checkModel("single");
        checkOutput("single.latency_ok",
                    {31'd0, ((ready_rise_cyc - p) >= LAT_MIN) && ((ready_rise_cyc - p) <= LAT_MAX)}, 32'd1);
        @(negedge clk_50m);
        ready_clr = 1'b1;
        @(negedge clk_50m);
        ready_clr = 1'b0;
        exp_ready = 1'b0;
        checkOutput("single.ready_after_clr", {31'd0, ready}, {31'd0, exp_ready});
        waitClocks(20);

        // Random bytes, optionally acknowledged
        for (int i = 0; i < 3; i++) begin
            rb     = 8'($urandom_range(0, 255));
            do_clr = 1'($urandom_range(0, 1));
            applyStimulus(rb, 1'b1);
            modelGoodFrame(rb);
            checkModel("random");
            if (do_clr) pulseClear();
            waitClocks(10);
        end
        pulseClear();
        waitClocks(10);

        // Back-to-back frames without acknowledge
        applyStimulus(8'hA5, 1'b1);
        modelGoodFrame(8'hA5);
        applyStimulus(8'h3C, 1'b1);
        modelGoodFrame(8'h3C);
        checkModel("b2b");
        pulseClear();
        checkModel("b2b_clr");
        waitClocks(20);

        // Short low glitch on the line
        b0  = busy_cycles;
        fc0 = fe_cycles;
        Rx  = 1'b0;
        waitClocks(5 * OVS);
        Rx  = 1'b1;
        waitClocks(400);
        checkOutput("glitch.busy_seen", {31'd0, busy_cycles > b0}, 32'd1);
        checkOutput("glitch.Rx_busy", {31'd0, Rx_busy}, 32'd0);
        checkOutput("glitch.fe_cycles", fe_cycles - fc0, 32'd0);
        checkModel("glitch");

        // Stop bit forced low
        fc0 = fe_cycles;
        fp0 = fe_pulses;
        applyStimulus(8'hFF, 1'b0);
        waitClocks(600);
        checkOutput("framing.fe_cycles", fe_cycles - fc0, 32'd1);
        checkOutput("framing.fe_pulses", fe_pulses - fp0, 32'd1);
        checkOutput("framing.Rx_busy", {31'd0, Rx_busy}, 32'd0);
        checkModel("framing");

        // Reset in the middle of a frame while a byte is pending
        applyStimulus(8'h5A, 1'b1);
        modelGoodFrame(8'h5A);
        checkModel("pre_reset");
        waitClocks(10);
        fork
            applyStimulus(8'h81, 1'b1);
            begin
                waitClocks(BIT_CLKS * 5 + BIT_CLKS / 2);
                #3 rst_n = 1'b0;
                #1 checkResetValues("midreset");
            end
        join
        exp_data    = 8'h00;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
        waitClocks(20);
        rst_n = 1'b1;
        waitClocks(10);
        checkModel("post_reset");
        applyStimulus(8'h81, 1'b1);
        modelGoodFrame(8'h81);
        checkModel("clean81");
        pulseClear();
        waitClocks(10);

        // Acknowledge in the exact completion cycle of the next byte
        applyStimulus(8'h12, 1'b1);
        modelGoodFrame(8'h12);
        checkModel("hold12");
        waitClocks(10);
        p = cyc;
        k = p + 2;
        while ((k % OVS) != (OVS - 1)) k++;
        kc    = k + 152 * OVS;
        guard = 0;
        fork
            applyStimulus(8'h34, 1'b1);
            begin
                while (cyc != kc && guard < 10000) begin
                    @(negedge clk_50m);
                    guard++;
                end
                ready_clr = 1'b1;
                @(negedge clk_50m);
                ready_clr = 1'b0;
            end
        join
        checkOutput("simul.align_in_budget", {31'd0, guard < 10000}, 32'd1);
        exp_data    = 8'h34;
        exp_ready   = 1'b1;
        exp_overrun = 1'b0;
        checkModel("simul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
